// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit feeding the architectural HI/LO registers.
// One shift-add (multiply) or restoring shift-subtract (divide) step per cycle.
module muldiv_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  MD_start,
  input  logic [1:0]            MD_op,
  input  logic [DATA_WIDTH-1:0] MD_operand_a,
  input  logic [DATA_WIDTH-1:0] MD_operand_b,
  input  logic                  MD_hi_we,
  input  logic                  MD_lo_we,
  input  logic [DATA_WIDTH-1:0] MD_wdata,
  output logic                  MD_busy,
  output logic                  MD_done,
  output logic                  MD_div_by_zero,
  output logic [DATA_WIDTH-1:0] MD_hi,
  output logic [DATA_WIDTH-1:0] MD_lo
);

  // state    | meaning
  // S_IDLE   | waiting for MD_start; MTHI/MTLO honoured
  // S_RUN    | DATA_WIDTH iteration steps, counter counts down to 0
  // S_FINISH | sign fix-up, HI/LO written, done pulse follows
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      op_q, op_d;
  logic            a_neg_q, a_neg_d, b_neg_q, b_neg_d;
  logic [W-1:0]    a_mag_q, a_mag_d, b_mag_q, b_mag_d;
  logic [2*W-1:0]  acc_q, acc_d;
  logic [W:0]      rem_q, rem_d;
  logic [W-1:0]    hi_q, hi_d, lo_q, lo_d;
  logic            done_q, done_d, dbz_q, dbz_d;

  logic            start_signed;
  logic [W-1:0]    in_a_mag, in_b_mag;
  logic            op_signed, is_div;
  logic [W:0]      mul_sum;
  logic [W+1:0]    rem_sh, rem_diff;
  logic            quo_bit;
  logic [2*W-1:0]  prod_fix;
  logic [W-1:0]    quo_fix, rmd_fix, a_raw;

  assign start_signed = ~MD_op[0];
  assign in_a_mag = (start_signed && MD_operand_a[W-1]) ? -MD_operand_a : MD_operand_a;
  assign in_b_mag = (start_signed && MD_operand_b[W-1]) ? -MD_operand_b : MD_operand_b;

  assign op_signed = ~op_q[0];
  assign is_div    = op_q[1];

  // Multiply: acc = {partial product, remaining multiplier bits}.
  assign mul_sum = {1'b0, acc_q[2*W-1:W]} + {1'b0, (acc_q[0] ? a_mag_q : {W{1'b0}})};

  // Divide: acc low half shifts dividend out and quotient bits in.
  assign rem_sh   = {rem_q, acc_q[W-1]};
  assign rem_diff = rem_sh - {2'b00, b_mag_q};
  assign quo_bit  = ~rem_diff[W+1];

  assign prod_fix = (op_signed && (a_neg_q ^ b_neg_q)) ? -acc_q : acc_q;
  assign quo_fix  = (op_signed && (a_neg_q ^ b_neg_q)) ? -acc_q[W-1:0] : acc_q[W-1:0];
  assign rmd_fix  = (op_signed && a_neg_q) ? -rem_q[W-1:0] : rem_q[W-1:0];
  assign a_raw    = (op_signed && a_neg_q) ? -a_mag_q : a_mag_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_neg_d = a_neg_q;
    b_neg_d = b_neg_q;
    a_mag_d = a_mag_q;
    b_mag_d = b_mag_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    dbz_d   = dbz_q;
    case (state_q)
      S_IDLE: begin
        if (MD_hi_we) hi_d = MD_wdata;
        if (MD_lo_we) lo_d = MD_wdata;
        if (MD_start) begin
          state_d = S_RUN;
          cnt_d   = CW'(W - 1);
          op_d    = MD_op;
          a_neg_d = MD_operand_a[W-1];
          b_neg_d = MD_operand_b[W-1];
          a_mag_d = in_a_mag;
          b_mag_d = in_b_mag;
          acc_d   = MD_op[1] ? {{W{1'b0}}, in_a_mag} : {{W{1'b0}}, in_b_mag};
          rem_d   = '0;
          dbz_d   = 1'b0;
        end
      end
      S_RUN: begin
        if (is_div) begin
          acc_d = {acc_q[2*W-1:W], acc_q[W-2:0], quo_bit};
          rem_d = quo_bit ? rem_diff[W:0] : rem_sh[W:0];
        end else begin
          acc_d = {mul_sum, acc_q[W-1:1]};
        end
        if (cnt_q == '0) state_d = S_FINISH;
        else             cnt_d   = cnt_q - CW'(1);
      end
      S_FINISH: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        if (!is_div) begin
          {hi_d, lo_d} = prod_fix;
        end else if (b_mag_q == '0) begin
          hi_d  = a_raw;
          lo_d  = '1;
          dbz_d = 1'b1;
        end else begin
          hi_d = rmd_fix;
          lo_d = quo_fix;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_neg_q <= 1'b0;
      b_neg_q <= 1'b0;
      a_mag_q <= '0;
      b_mag_q <= '0;
      acc_q   <= '0;
      rem_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_neg_q <= a_neg_d;
      b_neg_q <= b_neg_d;
      a_mag_q <= a_mag_d;
      b_mag_q <= b_mag_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  end

  assign MD_busy        = (state_q != S_IDLE);
  assign MD_done        = done_q;
  assign MD_div_by_zero = dbz_q;
  assign MD_hi          = hi_q;
  assign MD_lo          = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases plus random ops
// compared against a plain-arithmetic HI/LO model.
module tb_muldiv_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        MD_start;
  logic [1:0]  MD_op;
  logic [31:0] MD_operand_a, MD_operand_b;
  logic        MD_hi_we, MD_lo_we;
  logic [31:0] MD_wdata;
  logic        MD_busy, MD_done, MD_div_by_zero;
  logic [31:0] MD_hi, MD_lo;

  int checks = 0;
  int failures = 0;

  muldiv_unit #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .MD_start(MD_start), .MD_op(MD_op),
    .MD_operand_a(MD_operand_a), .MD_operand_b(MD_operand_b),
    .MD_hi_we(MD_hi_we), .MD_lo_we(MD_lo_we), .MD_wdata(MD_wdata),
    .MD_busy(MD_busy), .MD_done(MD_done), .MD_div_by_zero(MD_div_by_zero),
    .MD_hi(MD_hi), .MD_lo(MD_lo)
  );

  always #5 clk = ~clk;

  function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] hi, output logic [31:0] lo, output logic dbz);
    longint sa, sb, q, r;
    longint unsigned ua, ub, up;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'b0, a};
    ub = {32'b0, b};
    dbz = 1'b0;
    hi = '0;
    lo = '0;
    case (op)
      2'b00: {hi, lo} = sa * sb;
      2'b01: begin up = ua * ub; {hi, lo} = up; end
      default: begin
        if (b == 32'd0) begin
          hi = a; lo = 32'hFFFF_FFFF; dbz = 1'b1;
        end else if (op == 2'b10) begin
          q = sa / sb; r = sa % sb;
          lo = q[31:0]; hi = r[31:0];
        end else begin
          up = ua / ub; lo = up[31:0];
          up = ua % ub; hi = up[31:0];
        end
      end
    endcase
  endfunction

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int busy_n, output bit held, output bit dbz0);
    logic [31:0] h0, l0;
    @(negedge clk);
    h0 = MD_hi; l0 = MD_lo;
    MD_op = op; MD_operand_a = a; MD_operand_b = b; MD_start = 1'b1;
    @(posedge clk); #1;
    MD_start = 1'b0;
    lat = 0; busy_n = MD_busy ? 1 : 0; held = 1'b1; dbz0 = MD_div_by_zero;
    while (MD_done !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (MD_done !== 1'b1) begin
        if (MD_busy) busy_n++;
        if (MD_hi !== h0 || MD_lo !== l0) held = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({MD_hi, MD_lo} !== 64'h0) begin failures++; $display("FAIL reset_hilo: got %h %h want 0 0", MD_hi, MD_lo); end
    checks++;
    if ({MD_busy, MD_done} !== 2'b00) begin failures++; $display("FAIL reset_busy_done: got %b%b want 00", MD_busy, MD_done); end
    checks++;
    if (MD_div_by_zero !== 1'b0) begin failures++; $display("FAIL reset_dbz: got %b want 0", MD_div_by_zero); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_multu();
    int lat, bn; bit held, d0;
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bn, held, d0);
    checks++;
    if ({MD_hi, MD_lo} !== 64'hFFFF_FFFE_0000_0001) begin failures++; $display("FAIL multu_max: got %h_%h want fffffffe_00000001", MD_hi, MD_lo); end
    checks++;
    if (lat != 33) begin failures++; $display("FAIL multu_latency: got %0d want 33", lat); end
    checks++;
    if (bn != 33) begin failures++; $display("FAIL multu_busy_cycles: got %0d want 33", bn); end
    checks++;
    if (!held) begin failures++; $display("FAIL multu_hilo_hold: HI/LO changed during run, want held"); end
    checks++;
    if (MD_busy !== 1'b0) begin failures++; $display("FAIL multu_busy_at_done: got %b want 0", MD_busy); end
    @(posedge clk); #1;
    checks++;
    if (MD_done !== 1'b0) begin failures++; $display("FAIL multu_done_width: got %b want 0 one cycle later", MD_done); end
  endtask

  task automatic test_mult();
    int lat, bn; bit held, d0;
    run_op(2'b00, 32'hFFFF_FFFD, 32'd7, lat, bn, held, d0);
    checks++;
    if ({MD_hi, MD_lo} !== 64'hFFFF_FFFF_FFFF_FFEB) begin failures++; $display("FAIL mult_neg3x7: got %h_%h want ffffffff_ffffffeb", MD_hi, MD_lo); end
    checks++;
    if (lat != 33) begin failures++; $display("FAIL mult_latency: got %0d want 33", lat); end
    run_op(2'b00, 32'h8000_0000, 32'h8000_0000, lat, bn, held, d0);
    checks++;
    if ({MD_hi, MD_lo} !== 64'h4000_0000_0000_0000) begin failures++; $display("FAIL mult_minxmin: got %h_%h want 40000000_00000000", MD_hi, MD_lo); end
  endtask

  task automatic test_div();
    int lat, bn; bit held, d0;
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, lat, bn, held, d0);
    checks++;
    if ({MD_hi, MD_lo} !== 64'hFFFF_FFFF_FFFF_FFFD) begin failures++; $display("FAIL div_neg7by2: got hi=%h lo=%h want ffffffff fffffffd", MD_hi, MD_lo); end
    checks++;
    if (lat != 33) begin failures++; $display("FAIL div_latency: got %0d want 33", lat); end
    run_op(2'b11, 32'd100, 32'd7, lat, bn, held, d0);
    checks++;
    if (MD_lo !== 32'd14 || MD_hi !== 32'd2) begin failures++; $display("FAIL divu_100by7: got hi=%0d lo=%0d want 2 14", MD_hi, MD_lo); end
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, lat, bn, held, d0);
    checks++;
    if (MD_lo !== 32'h8000_0000 || MD_hi !== 32'h0) begin failures++; $display("FAIL div_overflow: got hi=%h lo=%h want 0 80000000", MD_hi, MD_lo); end
    checks++;
    if (MD_div_by_zero !== 1'b0) begin failures++; $display("FAIL div_overflow_dbz: got %b want 0", MD_div_by_zero); end
  endtask

  task automatic test_div_by_zero();
    int lat, bn; bit held, d0;
    run_op(2'b11, 32'd5, 32'd0, lat, bn, held, d0);
    checks++;
    if (MD_hi !== 32'd5 || MD_lo !== 32'hFFFF_FFFF) begin failures++; $display("FAIL divu_by0_result: got hi=%h lo=%h want 5 ffffffff", MD_hi, MD_lo); end
    checks++;
    if (MD_div_by_zero !== 1'b1 || lat != 33) begin failures++; $display("FAIL divu_by0_flag: got flag=%b lat=%0d want 1 33", MD_div_by_zero, lat); end
    @(posedge clk); #1;
    checks++;
    if (MD_div_by_zero !== 1'b1) begin failures++; $display("FAIL dbz_hold: got %b want 1", MD_div_by_zero); end
    run_op(2'b10, 32'hFFFF_FFF9, 32'd0, lat, bn, held, d0);
    checks++;
    if (MD_hi !== 32'hFFFF_FFF9 || MD_lo !== 32'hFFFF_FFFF || MD_div_by_zero !== 1'b1) begin
      failures++; $display("FAIL div_neg_by0: got hi=%h lo=%h flag=%b want fffffff9 ffffffff 1", MD_hi, MD_lo, MD_div_by_zero);
    end
    run_op(2'b01, 32'd2, 32'd3, lat, bn, held, d0);
    checks++;
    if (d0 !== 1'b0) begin failures++; $display("FAIL dbz_clear_on_start: got %b want 0", d0); end
    checks++;
    if ({MD_hi, MD_lo} !== 64'd6 || MD_div_by_zero !== 1'b0) begin failures++; $display("FAIL multu_2x3: got %h_%h flag=%b want 0_6 0", MD_hi, MD_lo, MD_div_by_zero); end
  endtask

  task automatic test_back_to_back();
    int lat, bn; bit held, d0;
    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bn, held, d0);
    checks++;
    if ({MD_hi, MD_lo} !== 64'd1) begin failures++; $display("FAIL b2b_first: got %h_%h want 0_1", MD_hi, MD_lo); end
    run_op(2'b10, 32'd7, 32'hFFFF_FFFE, lat, bn, held, d0);
    checks++;
    if (MD_lo !== 32'hFFFF_FFFD || MD_hi !== 32'd1) begin failures++; $display("FAIL b2b_second: got hi=%h lo=%h want 1 fffffffd", MD_hi, MD_lo); end
    checks++;
    if (lat != 33) begin failures++; $display("FAIL b2b_latency: got %0d want 33", lat); end
  endtask

  task automatic test_busy_ignore();
    int n; bit held; logic [31:0] h0;
    @(negedge clk);
    h0 = MD_hi;
    MD_op = 2'b01; MD_operand_a = 32'h0001_2345; MD_operand_b = 32'h0000_0100; MD_start = 1'b1;
    @(posedge clk); #1;
    MD_start = 1'b0;
    n = 0; held = 1'b1;
    while (MD_done !== 1'b1 && n < 40) begin
      if (n == 5) begin
        @(negedge clk);
        MD_start = 1'b1; MD_op = 2'b10; MD_operand_a = 32'd99; MD_operand_b = 32'd3;
        MD_hi_we = 1'b1; MD_wdata = 32'h0000_DEAD;
      end
      @(posedge clk); #1;
      n++;
      MD_start = 1'b0; MD_hi_we = 1'b0;
      if (MD_done !== 1'b1 && MD_hi !== h0) held = 1'b0;
    end
    checks++;
    if ({MD_hi, MD_lo} !== 64'h0000_0000_0123_4500) begin failures++; $display("FAIL busy_ignore_result: got %h_%h want 00000000_01234500", MD_hi, MD_lo); end
    checks++;
    if (n != 33) begin failures++; $display("FAIL busy_ignore_latency: got %0d want 33", n); end
    checks++;
    if (!held) begin failures++; $display("FAIL busy_ignore_mthi: HI changed while busy, want held"); end
  endtask

  task automatic test_mthi_mtlo();
    logic [31:0] h0;
    @(negedge clk);
    h0 = MD_hi;
    MD_lo_we = 1'b1; MD_wdata = 32'h0000_1234;
    @(posedge clk); #1;
    MD_lo_we = 1'b0;
    checks++;
    if (MD_lo !== 32'h1234 || MD_hi !== h0) begin failures++; $display("FAIL mtlo: got hi=%h lo=%h want %h 00001234", MD_hi, MD_lo, h0); end
    @(negedge clk);
    MD_hi_we = 1'b1; MD_wdata = 32'hCAFE_0001;
    @(posedge clk); #1;
    MD_hi_we = 1'b0;
    checks++;
    if (MD_hi !== 32'hCAFE_0001 || MD_lo !== 32'h1234) begin failures++; $display("FAIL mthi: got hi=%h lo=%h want cafe0001 00001234", MD_hi, MD_lo); end
  endtask

  task automatic test_reset_midop();
    int lat, bn; bit held, d0, saw_done;
    @(negedge clk);
    MD_op = 2'b10; MD_operand_a = 32'd1000; MD_operand_b = 32'd3; MD_start = 1'b1;
    @(posedge clk); #1;
    MD_start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (MD_busy !== 1'b0 || MD_done !== 1'b0) begin failures++; $display("FAIL midop_reset_busy: got busy=%b done=%b want 0 0", MD_busy, MD_done); end
    checks++;
    if ({MD_hi, MD_lo} !== 64'h0) begin failures++; $display("FAIL midop_reset_hilo: got %h_%h want 0_0", MD_hi, MD_lo); end
    saw_done = 1'b0;
    repeat (3) begin @(posedge clk); #1; if (MD_done === 1'b1) saw_done = 1'b1; end
    @(negedge clk);
    rst = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (MD_done === 1'b1 || MD_busy === 1'b1) saw_done = 1'b1; end
    checks++;
    if (saw_done) begin failures++; $display("FAIL midop_no_done: done/busy seen after reset, want none"); end
    run_op(2'b01, 32'd12, 32'd12, lat, bn, held, d0);
    checks++;
    if ({MD_hi, MD_lo} !== 64'd144 || lat != 33) begin failures++; $display("FAIL post_reset_multu: got %h_%h lat=%0d want 0_90 33", MD_hi, MD_lo, lat); end
  endtask

  task automatic test_random();
    int lat, bn; bit held, d0;
    logic [1:0] op; logic [31:0] a, b, eh, el; logic ed;
    for (int i = 0; i < 24; i++) begin
      op = 2'($urandom_range(0, 3));
      a = (i % 6 == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 15));
        2: b = 32'hFFFF_FFFF;
        3: b = 32'h8000_0000;
        default: b = $urandom;
      endcase
      model(op, a, b, eh, el, ed);
      run_op(op, a, b, lat, bn, held, d0);
      checks++;
      if (MD_hi !== eh || MD_lo !== el) begin
        failures++; $display("FAIL rand_result[%0d] op=%0d a=%h b=%h: got hi=%h lo=%h want %h %h", i, op, a, b, MD_hi, MD_lo, eh, el);
      end
      checks++;
      if (MD_div_by_zero !== ed) begin failures++; $display("FAIL rand_dbz[%0d]: got %b want %b", i, MD_div_by_zero, ed); end
      checks++;
      if (lat != 33 || bn != 33) begin failures++; $display("FAIL rand_timing[%0d]: got lat=%0d busy=%0d want 33 33", i, lat, bn); end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; MD_start = 1'b0; MD_op = 2'b00; MD_operand_a = '0; MD_operand_b = '0;
    MD_hi_we = 1'b0; MD_lo_we = 1'b0; MD_wdata = '0;
    test_reset();
    test_multu();
    test_mult();
    test_div();
    test_div_by_zero();
    test_back_to_back();
    test_busy_ignore();
    test_mthi_mtlo();
    test_reset_midop();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit in the execute stage, directly downstream of the register file.
- Consumes the rs/rt read data and implements MULT, MULTU, DIV, DIVU, MTHI and MTLO into architectural HI/LO registers.
- HI/LO values feed the MFHI/MFLO write-back path into the register file.
- Exposes busy/done so the pipeline can stall.

Parameters:
- DATA_WIDTH, 32, operand width; iteration count equals DATA_WIDTH.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- MD_start  input  1  request to start the operation given by MD_op.
- MD_op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- MD_operand_a  input  DATA_WIDTH  rs value (multiplicand / dividend).
- MD_operand_b  input  DATA_WIDTH  rt value (multiplier / divisor).
- MD_hi_we  input  1  MTHI write enable.
- MD_lo_we  input  1  MTLO write enable.
- MD_wdata  input  DATA_WIDTH  MTHI/MTLO data.
- MD_busy  output  1  high while an operation is in flight.
- MD_done  output  1  one-cycle pulse when HI/LO receive a result.
- MD_div_by_zero  output  1  set with MD_done for a divide with divisor 0; cleared on next accepted start.
- MD_hi  output  DATA_WIDTH  HI register.
- MD_lo  output  DATA_WIDTH  LO register.

Behaviour:
- Reset (async, any state):
  - state=IDLE; HI=LO=0.
  - MD_busy=0, MD_done=0, MD_div_by_zero=0.
  - Iteration counter=0.
- States: IDLE, RUN, FINISH.
- IDLE:
  - MD_start=1 is accepted at edge E0.
  - Operands are latched as magnitudes for signed ops (MULT, DIV); raw values for unsigned ops.
  - Operand sign bits and op code are latched; counter loads DATA_WIDTH-1; MD_div_by_zero clears.
  - Next state is RUN; MD_busy=1 from E0.
- RUN:
  - Multiply: one shift-add step per cycle into a 2*DATA_WIDTH accumulator.
  - Divide: one restoring shift-subtract step per cycle (quotient bit per cycle, remainder register DATA_WIDTH+1 bits).
  - The counter decrements each cycle; after DATA_WIDTH edges (E32) the state moves to FINISH.
- FINISH (one cycle, edge E33):
  - Sign correction is applied and HI/LO are written.
  - MD_done=1 for exactly one cycle; MD_busy=0.
  - Next state is IDLE.
  - Result latency is 33 edges from the start edge. A new start can be accepted in the cycle where MD_done is high.
- Multiply result:
  - {HI,LO} = 64-bit product.
  - MULT: negate the 64-bit product when the operand signs differ.
- Divide result:
  - LO = quotient, HI = remainder.
  - DIV: quotient negated when the signs differ; remainder takes the sign of the dividend.
  - Overflow case 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0. This falls out of magnitude arithmetic truncated to DATA_WIDTH.
- Divide by zero (DIV or DIVU, divisor=0):
  - Full latency is still taken.
  - HI = MD_operand_a as latched raw, LO = all ones.
  - MD_div_by_zero=1 at the same edge as MD_done and held until the next accepted start.
- MD_start while MD_busy=1 is ignored; the in-flight operation and its operands are unaffected.
- MTHI/MTLO:
  - Honoured only in IDLE; HI/LO update at the next edge.
  - Ignored while MD_busy=1.
  - If MD_hi_we/MD_lo_we coincides with an accepted MD_start, both take effect; the operation result later overwrites HI/LO.
- MD_hi/MD_lo are the registered architectural values. They never show intermediate accumulator contents; old values hold throughout RUN.
- Unused MD_op values do not exist (2-bit fully decoded).

Test Plan:
- Reset, then MULTU 0xFFFFFFFF × 0xFFFFFFFF -> after 33 edges HI=0xFFFFFFFE, LO=0x00000001; MD_done high exactly 1 cycle; MD_busy high for 33 cycles.
- MULT 0xFFFFFFFD (-3) × 7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB. MULT 0x80000000 × 0x80000000 -> HI=0x40000000, LO=0.
- DIV 0xFFFFFFF9 (-7) / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 100 / 7 -> LO=14, HI=2. DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU 5 / 0 -> HI=5, LO=0xFFFFFFFF, MD_div_by_zero=1 with MD_done; next MULTU 2×3 start clears the flag; result HI=0, LO=6.
- During RUN:
  - pulse MD_start with different operands, plus MD_hi_we with 0xDEAD -> both ignored; the original result is delivered.
  - Then in IDLE, MD_lo_we with 0x1234 -> LO=0x1234 next edge, HI unchanged.
- Assert rst 10 cycles into a DIV -> immediately MD_busy=0, HI=LO=0, MD_done never pulses. After release, MULTU 12×12 -> LO=144 at 33 edges.
